interrupt_arbiter: RTL and testbench
====================================

// Module: interrupt_arbiter
// PURPOSE
//  Central interrupt controller between the peripheral devices and the processor's
//  micro-controller. Replaces the ad-hoc timer/distance-tracker INTA chaining.
//  Collects level irqs, masks and prioritises them, raises one request to the core,
//  grants the acknowledge to exactly one device and drives its vector for the core.
// PARAMETERS
//  NUM_SRC      4             number of interrupt sources (2..8)
//  VEC_BASE     32'h0000_0010 vector = VEC_BASE + winning source index
//  CLR_TIMEOUT  16            cycles to wait for granted irq to drop after ack (>=2)
// PORTS
//  clk        in   1        system clock
//  rst        in   1        reset; synchronous, active-high
//  irq        in   NUM_SRC  level interrupt requests from devices
//  ie         in   1        processor interrupt-enable (IE register)
//  int_ack    in   1        IntAck from micro-controller, level, held over vector read
//  mask_wr    in   1        write enable for mask register
//  mask_din   in   NUM_SRC  mask write data (1 = source enabled)
//  int_req    out  1        request to core (feeds OnInt)
//  ack_out    out  NUM_SRC  one-hot per-device acknowledge
//  vec_valid  out  1        vec is valid (core may drive it onto Bus)
//  vec        out  32       interrupt vector
//  mask_q     out  NUM_SRC  current mask
//  err        out  1        sticky: granted irq failed to clear within CLR_TIMEOUT
// BEHAVIOUR
//  - All outputs registered. Reset: int_req=0, ack_out=0, vec_valid=0, vec=0,
//    err=0, mask_q=all ones, state=IDLE, rr_ptr=0, timer=0. Reset mid-operation
//    aborts any grant the next cycle; no ack_out pulse survives reset.
//  - eligible = irq & mask_q. mask_wr takes effect the cycle after the write.
//  - FSM IDLE -> PEND -> ACK -> WAIT_CLR -> IDLE:
//   IDLE: if ie && |eligible, latch winner index, int_req=1 next cycle (1-cycle
//    latency from sampled irq). Otherwise stay.
//   PEND: int_req=1. If int_ack: go ACK. Else if !ie or !eligible[winner]
//    (withdrawn/masked): int_req=0, back to IDLE (re-arbitrate). int_ack has priority
//    over withdrawal in the same cycle.
//   ACK: int_req=0, ack_out=onehot(winner), vec_valid=1, vec=VEC_BASE+winner,
//    held while int_ack=1. On int_ack=0: clear ack_out/vec_valid/vec, go WAIT_CLR,
//    timer=0.
//   WAIT_CLR: if !irq[winner]: IDLE. Else timer++; at timer==CLR_TIMEOUT-1 set err,
//    go IDLE (source re-eligible; err stays set until rst).
//  - New irqs arriving in PEND/ACK/WAIT_CLR are not lost (level) and are
//    arbitrated on return to IDLE. Winner is never changed after latching.
//  - Simultaneous eligible sources: see CONFIGURATION. Index width = clog2(NUM_SRC).
//  - vec arithmetic: 32-bit add, index zero-extended, wrap modulo 2^32.
// CONFIGURATION
//  INT_ARB_ROUND_ROBIN_EN defined: rotating priority; search starts at rr_ptr,
//   rr_ptr <= winner+1 (mod NUM_SRC) on entering ACK; withdrawal does not move it.
//  Not defined: fixed priority, lowest index wins; rr_ptr unused (held at 0).
// STRUCTURE
//  Package int_arb_pkg: state enum (IDLE,PEND,ACK,WAIT_CLR), default VEC_BASE,
//  CLR_TIMEOUT constants. One sub-module: int_arb_prio_pick (combinational
//  rotate/priority picker: in eligible, start -> found, index).
// TESTING
//  1 rst; ie=1; irq=4'b0010 -> int_req=1 next cycle; int_ack 2 cyc -> ack_out=0010,
//    vec=32'h11; drop irq -> IDLE, int_req=0.
//  2 irq=4'b1010 together, fixed prio -> winner 1 (vec 32'h11); with
//    INT_ARB_ROUND_ROBIN_EN, second round winner 3 (vec 32'h13).
//  3 ie=0, irq=4'b0001 -> int_req stays 0; ie=1 -> int_req=1 next cycle.
//  4 PEND, mask_din=4'b1110 write -> int_req drops within 2 cyc, no ack_out ever.
//  5 after ack hold irq[2] high 16 cyc -> err=1, re-request, vec 32'h12.
//  6 rst asserted during ACK -> next cycle all outputs 0, mask_q=4'b1111.

Source files
------------

// File: rtl/int_arb_pkg.sv
// Shared types and defaults for the interrupt arbiter.
package int_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    ACK      = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_VEC_BASE    = 32'h0000_0010;
  localparam int          DEFAULT_CLR_TIMEOUT = 16;

endpackage

// File: rtl/int_arb_prio_pick.sv
// Combinational priority picker: first set bit of eligible, searching upward
// from start and wrapping at NUM_SRC.
module int_arb_prio_pick #(
  parameter int NUM_SRC = 4,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] eligible,
  input  logic [IW-1:0]      start,
  output logic               found,
  output logic [IW-1:0]      index
);

  int j;

  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(start) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && eligible[j]) begin
        found = 1'b1;
        index = IW'(j);
      end
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: masks and prioritises level irqs, handshakes with the core.
// Define INT_ARB_ROUND_ROBIN_EN for rotating priority; default is fixed (lowest index).
module interrupt_arbiter
  import int_arb_pkg::*;
#(
  parameter int          NUM_SRC     = 4,
  parameter logic [31:0] VEC_BASE    = DEFAULT_VEC_BASE,
  parameter int          CLR_TIMEOUT = DEFAULT_CLR_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               ie,
  input  logic               int_ack,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_din,
  output logic               int_req,
  output logic [NUM_SRC-1:0] ack_out,
  output logic               vec_valid,
  output logic [31:0]        vec,
  output logic [NUM_SRC-1:0] mask_q,
  output logic               err
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int TW = $clog2(CLR_TIMEOUT + 1);

  state_t             state, state_n;
  logic [IW-1:0]      winner, winner_n;
  logic [IW-1:0]      rr_ptr, rr_ptr_n;
  logic [TW-1:0]      timer, timer_n;
  logic               int_req_n, vec_valid_n, err_n;
  logic [NUM_SRC-1:0] ack_out_n;
  logic [31:0]        vec_n;
  logic [NUM_SRC-1:0] eligible;
  logic               pick_found;
  logic [IW-1:0]      pick_index;

  assign eligible = irq & mask_q;

  // Without rotation rr_ptr never leaves 0, so the picker is plain fixed priority.
  int_arb_prio_pick #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_pick (
    .eligible (eligible),
    .start    (rr_ptr),
    .found    (pick_found),
    .index    (pick_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      winner    <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      int_req   <= 1'b0;
      ack_out   <= '0;
      vec_valid <= 1'b0;
      vec       <= '0;
      err       <= 1'b0;
      mask_q    <= '1;
    end else begin
      state     <= state_n;
      winner    <= winner_n;
      rr_ptr    <= rr_ptr_n;
      timer     <= timer_n;
      int_req   <= int_req_n;
      ack_out   <= ack_out_n;
      vec_valid <= vec_valid_n;
      vec       <= vec_n;
      err       <= err_n;
      if (mask_wr) mask_q <= mask_din;
    end
  end

  always_comb begin
    state_n     = state;
    winner_n    = winner;
    rr_ptr_n    = rr_ptr;
    timer_n     = timer;
    int_req_n   = int_req;
    ack_out_n   = ack_out;
    vec_valid_n = vec_valid;
    vec_n       = vec;
    err_n       = err;

    unique case (state)
      IDLE: begin
        if (ie && pick_found) begin
          winner_n  = pick_index;
          int_req_n = 1'b1;
          state_n   = PEND;
        end
      end
      // An acknowledge already on its way beats a withdrawn or masked request.
      PEND: begin
        if (int_ack) begin
          int_req_n   = 1'b0;
          ack_out_n   = {{(NUM_SRC-1){1'b0}}, 1'b1} << winner;
          vec_valid_n = 1'b1;
          vec_n       = VEC_BASE + 32'(winner);
          state_n     = ACK;
`ifdef INT_ARB_ROUND_ROBIN_EN
          rr_ptr_n    = (winner == IW'(NUM_SRC - 1)) ? '0 : winner + IW'(1);
`endif
        end else if (!ie || !eligible[winner]) begin
          int_req_n = 1'b0;
          state_n   = IDLE;
        end
      end
      ACK: begin
        if (!int_ack) begin
          ack_out_n   = '0;
          vec_valid_n = 1'b0;
          vec_n       = '0;
          timer_n     = '0;
          state_n     = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (!irq[winner]) begin
          state_n = IDLE;
        end else if (timer == TW'(CLR_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter (either priority mode).
module tb_interrupt_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq = '0;
  logic        ie = 1'b0;
  logic        int_ack = 1'b0;
  logic        mask_wr = 1'b0;
  logic [3:0]  mask_din = '0;
  logic        int_req;
  logic [3:0]  ack_out;
  logic        vec_valid;
  logic [31:0] vec;
  logic [3:0]  mask_q;
  logic        err;

  int num_checks = 0;
  int num_fails  = 0;

  interrupt_arbiter #(
    .NUM_SRC     (4),
    .VEC_BASE    (32'h0000_0010),
    .CLR_TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .ie        (ie),
    .int_ack   (int_ack),
    .mask_wr   (mask_wr),
    .mask_din  (mask_din),
    .int_req   (int_req),
    .ack_out   (ack_out),
    .vec_valid (vec_valid),
    .vec       (vec),
    .mask_q    (mask_q),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] irq_v, input logic ie_v, input logic ack_v);
    irq     = irq_v;
    ie      = ie_v;
    int_ack = ack_v;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    mask_wr = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: single source handshake
    doReset();
    checkOutput("rst_int_req", 32'(int_req), 32'd0);
    checkOutput("rst_ack_out", 32'(ack_out), 32'd0);
    checkOutput("rst_vec_valid", 32'(vec_valid), 32'd0);
    checkOutput("rst_vec", vec, 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_mask", 32'(mask_q), 32'hf);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    step(1);
    checkOutput("t1_int_req", 32'(int_req), 32'd1);
    int_ack = 1'b1;
    step(1);
    checkOutput("t1_ack_out", 32'(ack_out), 32'b0010);
    checkOutput("t1_vec", vec, 32'h11);
    checkOutput("t1_vec_valid", 32'(vec_valid), 32'd1);
    checkOutput("t1_req_low", 32'(int_req), 32'd0);
    step(1);
    checkOutput("t1_ack_hold", 32'(ack_out), 32'b0010);
    int_ack = 1'b0;
    step(1);
    checkOutput("t1_ack_clear", 32'(ack_out), 32'd0);
    checkOutput("t1_vv_clear", 32'(vec_valid), 32'd0);
    irq = 4'b0000;
    step(2);
    checkOutput("t1_idle_req", 32'(int_req), 32'd0);

    // Test 2: two simultaneous sources, two rounds
    doReset();
    applyStimulus(4'b1010, 1'b1, 1'b0);
    step(1);
    checkOutput("t2_int_req", 32'(int_req), 32'd1);
    int_ack = 1'b1;
    step(1);
    checkOutput("t2_r1_vec", vec, 32'h11);
    checkOutput("t2_r1_ack", 32'(ack_out), 32'b0010);
    int_ack = 1'b0;
    step(1);
    irq = 4'b1000;
    step(1);
    irq = 4'b1010;
    step(1);
    checkOutput("t2_r2_req", 32'(int_req), 32'd1);
    int_ack = 1'b1;
    step(1);
`ifdef INT_ARB_ROUND_ROBIN_EN
    checkOutput("t2_r2_vec", vec, 32'h13);
    checkOutput("t2_r2_ack", 32'(ack_out), 32'b1000);
`else
    checkOutput("t2_r2_vec", vec, 32'h11);
    checkOutput("t2_r2_ack", 32'(ack_out), 32'b0010);
`endif
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(2);

    // Test 3: interrupt enable gating, then Test 4: mask withdrawal in PEND
    doReset();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    step(2);
    checkOutput("t3_ie_off", 32'(int_req), 32'd0);
    ie = 1'b1;
    step(1);
    checkOutput("t3_ie_on", 32'(int_req), 32'd1);
    mask_wr  = 1'b1;
    mask_din = 4'b1110;
    step(1);
    mask_wr = 1'b0;
    checkOutput("t4_mask_q", 32'(mask_q), 32'b1110);
    step(1);
    checkOutput("t4_req_drop", 32'(int_req), 32'd0);
    int_ack = 1'b1;
    step(2);
    checkOutput("t4_no_ack", 32'(ack_out), 32'd0);
    checkOutput("t4_no_req", 32'(int_req), 32'd0);
    checkOutput("t4_no_vv", 32'(vec_valid), 32'd0);
    int_ack = 1'b0;

    // Test 5: irq stuck after acknowledge -> err and re-request
    doReset();
    applyStimulus(4'b0100, 1'b1, 1'b0);
    step(1);
    int_ack = 1'b1;
    step(1);
    checkOutput("t5_vec", vec, 32'h12);
    int_ack = 1'b0;
    step(1);
    step(15);
    checkOutput("t5_err_before", 32'(err), 32'd0);
    step(1);
    checkOutput("t5_err_set", 32'(err), 32'd1);
    step(1);
    checkOutput("t5_rereq", 32'(int_req), 32'd1);
    int_ack = 1'b1;
    step(1);
    checkOutput("t5_revec", vec, 32'h12);
    checkOutput("t5_reack", 32'(ack_out), 32'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    step(2);
    checkOutput("t5_err_sticky", 32'(err), 32'd1);

    // Test 6: reset in the middle of an acknowledge
    applyStimulus(4'b0001, 1'b1, 1'b0);
    mask_wr  = 1'b1;
    mask_din = 4'b0011;
    step(1);
    mask_wr = 1'b0;
    checkOutput("t6_mask_q", 32'(mask_q), 32'b0011);
    int_ack = 1'b1;
    step(1);
    checkOutput("t6_ack_out", 32'(ack_out), 32'b0001);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("t6_int_req", 32'(int_req), 32'd0);
    checkOutput("t6_ack_out0", 32'(ack_out), 32'd0);
    checkOutput("t6_vec_valid", 32'(vec_valid), 32'd0);
    checkOutput("t6_vec", vec, 32'd0);
    checkOutput("t6_err", 32'(err), 32'd0);
    checkOutput("t6_mask_rst", 32'(mask_q), 32'hf);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
